imem_loadable: RTL and testbench
================================

# imem_loadable

Parametrised instruction memory for the pipelined MIPS core, successor to the fixed 256-word fetch ROM. The IF stage reads it through an asynchronous word-addressed fetch port. A byte-serial programming port (fed by the UART receiver) rewrites contents at run time, and the block holds the CPU while a load is in progress. Out-of-range fetches return NOP (32'h00000000) instead of aliasing.

## Interface
- ADDR_BITS, 8: word-address width; depth = 2^ADDR_BITS words of 32 bits.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_addr  in  32  byte address from PC; bits [1:0] ignored.
- instruction  out  32  fetched word (combinational).
- prog_start  in  1  one-cycle pulse: begin a load at word 0.
- prog_valid  in  1  prog_byte holds a valid byte.
- prog_byte  in  8  programming data, big-endian within each word.
- prog_ready  out  1  block accepts a byte this cycle.
- prog_end  in  1  one-cycle pulse: terminate the load.
- cpu_hold  out  1  stall request to the pipeline; PC must be reset to 0 when it falls.
- load_count  out  ADDR_BITS+1  words written in the current or most recent load.
- load_error  out  1  sticky error for the current or most recent load.
- prog_checksum  in  32  expected checksum, sampled with prog_end (present only under IMEM_CHECKSUM_EN).

## Operation
- States: IDLE, LOAD. Reset sets the state to IDLE and clears prog_ready, cpu_hold, load_count, load_error, the byte counter, the word pointer and the checksum. RAM contents are not cleared by reset.
- IDLE:
  - prog_ready=0 and cpu_hold=0.
  - prog_start moves to LOAD and clears the pointer, byte counter, load_count, load_error and checksum.
  - prog_end is ignored.
- LOAD:
  - prog_ready=1 and cpu_hold=1.
  - A byte is accepted on prog_valid & prog_ready. Byte n of a word (n=0..3) goes to bits [31-8n:24-8n].
  - On the 4th byte, the assembled word is written to RAM[pointer], then the pointer, load_count and checksum all update.
- Overflow: when load_count == 2^ADDR_BITS, further bytes are still accepted but discarded, and load_error is set.
- prog_end in LOAD returns to IDLE. If the byte counter ≠ 0, the partial word is dropped and load_error is set.
- prog_valid together with prog_end: the byte is processed first, and the end check uses the post-byte counter. A 4th byte arriving with prog_end is therefore written without error.
- prog_start during LOAD restarts the load with the same clears as from IDLE.
- prog_start and prog_end in the same cycle: prog_start wins.
- Fetch port:
  - instruction = RAM[fetch_addr[ADDR_BITS+1:2]] when fetch_addr[31:ADDR_BITS+2] == 0 and cpu_hold == 0.
  - Otherwise instruction = 32'h00000000.

## Timing
- Fetch has zero latency and is combinational from fetch_addr.
- A RAM write at edge k is visible on instruction from edge k onward.
- prog_start sampled at edge k: prog_ready and cpu_hold are 1 after edge k, and the first byte can be accepted at edge k+1.
- prog_end sampled at edge k: cpu_hold and prog_ready are 0 after edge k.
- Throughput is one byte per cycle, so a word is written every 4 accepted bytes.
- load_count and load_error update on the same edge as the event that causes them.
- Reset mid-load returns to IDLE after that edge. Words already written are retained; the partial word is lost.

## Configuration
- IMEM_CHECKSUM_EN defined:
  - The prog_checksum port exists.
  - The block keeps a running 32-bit wrap-around sum of all written words.
  - At prog_end, a mismatch between this sum and prog_checksum sets load_error. The comparison includes a word completed in the same cycle.
- IMEM_CHECKSUM_EN undefined: there is no port, no adder and no compare. load_error reflects only overflow and partial-word conditions.

## Test plan
- Reset, then fetch addresses 0 and 32'h400 (ADDR_BITS=8) → contents of RAM[0], and 0 for 32'h400 (out of range).
- prog_start, then bytes 20,04,00,03 and 0c,00,00,03, then prog_end → RAM[0]=32'h20040003, RAM[1]=32'h0c000003, load_count=2, load_error=0. cpu_hold is high from the start edge until the end edge.
- Fetch at fetch_addr=4 during LOAD → 0. After prog_end → 32'h0c000003.
- 6 bytes then prog_end → load_count=1 and load_error=1. RAM[1] keeps its old value.
- 4th byte together with prog_end → word written, load_error=0. Under IMEM_CHECKSUM_EN with prog_checksum=32'h2c040006 after the 2-word load → load_error=0, and with 32'h0 → load_error=1.
- Reset asserted after 5 bytes → state IDLE, cpu_hold=0, load_count=0, RAM[0] retains the new word. 2^ADDR_BITS+1 words loaded → load_error=1 and load_count=2^ADDR_BITS.

Source files
------------

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : imem_loadable
// Brief    : Run-time loadable instruction memory with an async fetch port and
//            a byte-serial programming port. Optional checksum verification is
//            enabled by defining IMEM_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loadable #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          fetch_addr,
  output logic [31:0]          instruction,
  input  logic                 prog_start,
  input  logic                 prog_valid,
  input  logic [7:0]           prog_byte,
  output logic                 prog_ready,
  input  logic                 prog_end,
  output logic                 cpu_hold,
  output logic [ADDR_BITS:0]   load_count,
  output logic                 load_error
`ifdef IMEM_CHECKSUM_EN
  ,
  input  logic [31:0]          prog_checksum
`endif
);

  localparam int                 DEPTH      = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};
  localparam logic [ADDR_BITS:0] COUNT_ONE  = (ADDR_BITS + 1)'(1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [31:0]          mem [DEPTH];

  logic [0:0]           state_q,      state_d;
  logic [1:0]           byte_cnt_q,   byte_cnt_d;
  logic [ADDR_BITS-1:0] ptr_q,        ptr_d;
  logic [ADDR_BITS:0]   load_count_q, load_count_d;
  logic                 load_error_q, load_error_d;
  logic [23:0]          word_buf_q,   word_buf_d;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]          checksum_q,   checksum_d;
`endif

  logic                 ram_we;
  logic [31:0]          ram_wdata;
  logic                 in_range;
  logic                 unused_addr_bits;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    ptr_d        = ptr_q;
    load_count_d = load_count_q;
    load_error_d = load_error_q;
    word_buf_d   = word_buf_q;
`ifdef IMEM_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    ram_we       = 1'b0;
    ram_wdata    = {word_buf_q, prog_byte};

    if (prog_start) begin
      // Start (or restart) wins over everything else in the same cycle.
      state_d      = ST_LOAD;
      byte_cnt_d   = 2'd0;
      ptr_d        = '0;
      load_count_d = '0;
      load_error_d = 1'b0;
`ifdef IMEM_CHECKSUM_EN
      checksum_d   = 32'h0;
`endif
    end else if (state_q == ST_LOAD) begin
      if (prog_valid) begin
        if (load_count_q == FULL_COUNT) begin
          load_error_d = 1'b1;
        end else begin
          case (byte_cnt_q)
            2'd0: word_buf_d[23:16] = prog_byte;
            2'd1: word_buf_d[15:8]  = prog_byte;
            2'd2: word_buf_d[7:0]   = prog_byte;
            default: begin
              ram_we       = 1'b1;
              ptr_d        = ptr_q + PTR_ONE;
              load_count_d = load_count_q + COUNT_ONE;
`ifdef IMEM_CHECKSUM_EN
              checksum_d   = checksum_q + ram_wdata;
`endif
            end
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end

      // End checks look at the post-byte state so a completing byte counts.
      if (prog_end) begin
        state_d = ST_IDLE;
        if (byte_cnt_d != 2'd0) begin
          load_error_d = 1'b1;
        end
`ifdef IMEM_CHECKSUM_EN
        if (checksum_d != prog_checksum) begin
          load_error_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      byte_cnt_q   <= 2'd0;
      ptr_q        <= '0;
      load_count_q <= '0;
      load_error_q <= 1'b0;
      word_buf_q   <= 24'h0;
`ifdef IMEM_CHECKSUM_EN
      checksum_q   <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      ptr_q        <= ptr_d;
      load_count_q <= load_count_d;
      load_error_q <= load_error_d;
      word_buf_q   <= word_buf_d;
`ifdef IMEM_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  // Contents survive reset; only the write is suppressed on a reset edge.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      mem[ptr_q] <= ram_wdata;
    end
  end

  generate
    if (ADDR_BITS < 30) begin : g_range_check
      assign in_range = (fetch_addr[31:ADDR_BITS+2] == '0);
    end else begin : g_full_space
      assign in_range = 1'b1;
    end
  endgenerate

  assign unused_addr_bits = ^fetch_addr[1:0];

  assign instruction = (in_range && !cpu_hold) ? mem[fetch_addr[ADDR_BITS+1:2]] : 32'h0000_0000;
  assign cpu_hold    = (state_q == ST_LOAD);
  assign prog_ready  = (state_q == ST_LOAD);
  assign load_count  = load_count_q;
  assign load_error  = load_error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loadable
// Brief    : Directed scoreboard bench for imem_loadable (IMEM_CHECKSUM_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_loadable;
  localparam int ADDR_BITS = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [31:0]         fetch_addr = 32'h0;
  logic [31:0]         instruction;
  logic                prog_start = 1'b0;
  logic                prog_valid = 1'b0;
  logic [7:0]          prog_byte = 8'h0;
  logic                prog_ready;
  logic                prog_end = 1'b0;
  logic                cpu_hold;
  logic [ADDR_BITS:0]  load_count;
  logic                load_error;
  logic [31:0]         prog_checksum = 32'h0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  imem_loadable #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_addr   (fetch_addr),
    .instruction  (instruction),
    .prog_start   (prog_start),
    .prog_valid   (prog_valid),
    .prog_byte    (prog_byte),
    .prog_ready   (prog_ready),
    .prog_end     (prog_end),
    .cpu_hold     (cpu_hold),
    .load_count   (load_count),
    .load_error   (load_error)
`ifdef IMEM_CHECKSUM_EN
    ,
    .prog_checksum(prog_checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty observed=%h required=queued_entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.value) else begin
      n_fail++;
      $error("FAIL %s observed=%h required=%h", e.tag, obs, e.value);
    end
  endtask

  task automatic expect_now(input string tag, input logic [31:0] exp_v, input logic [31:0] obs);
    push_exp(tag, exp_v);
    check(obs);
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_v);
    push_exp(tag, exp_v);
    fetch_addr = addr;
    #1;
    check(instruction);
  endtask

  task automatic send_byte(input logic [7:0] b);
    prog_valid = 1'b1;
    prog_byte  = b;
    tick();
    prog_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) send_byte(w[31-8*b -: 8]);
  endtask

  task automatic pulse_start();
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
  endtask

  task automatic pulse_end();
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    reset = 1'b0;
    expect_now("rst_cpu_hold",   32'd0, {31'd0, cpu_hold});
    expect_now("rst_prog_ready", 32'd0, {31'd0, prog_ready});
    expect_now("rst_load_count", 32'd0, 32'(load_count));
    expect_now("rst_load_error", 32'd0, {31'd0, load_error});
    expect_fetch("rst_fetch_oor", 32'h400, 32'h0);

    // Two-word load with matching checksum
    prog_checksum = 32'h2c040006;
    pulse_start();
    expect_now("start_cpu_hold",   32'd1, {31'd0, cpu_hold});
    expect_now("start_prog_ready", 32'd1, {31'd0, prog_ready});
    expect_fetch("hold_fetch_4", 32'h4, 32'h0);
    send_word(32'h20040003);
    send_word(32'h0c000003);
    expect_now("mid_load_count", 32'd2, 32'(load_count));
    expect_now("mid_cpu_hold",   32'd1, {31'd0, cpu_hold});
    pulse_end();
    expect_now("end_cpu_hold",   32'd0, {31'd0, cpu_hold});
    expect_now("end_prog_ready", 32'd0, {31'd0, prog_ready});
    expect_now("two_load_count", 32'd2, 32'(load_count));
    expect_now("two_load_error", 32'd0, {31'd0, load_error});
    expect_fetch("two_ram0", 32'h0, 32'h20040003);
    expect_fetch("two_ram1", 32'h4, 32'h0c000003);
    expect_fetch("addr_low_bits_ignored", 32'h7, 32'h0c000003);

    // prog_end while idle is ignored
    pulse_end();
    expect_now("idle_end_count", 32'd2, 32'(load_count));
    expect_now("idle_end_hold",  32'd0, {31'd0, cpu_hold});

    // Same load with wrong checksum: error only when checksum is built in
    prog_checksum = 32'h0;
    pulse_start();
    send_word(32'h20040003);
    send_word(32'h0c000003);
    pulse_end();
`ifdef IMEM_CHECKSUM_EN
    expect_now("cksum_bad_error", 32'd1, {31'd0, load_error});
`else
    expect_now("cksum_bad_error", 32'd0, {31'd0, load_error});
`endif
    expect_now("cksum_bad_count", 32'd2, 32'(load_count));

    // Partial word: 6 bytes then end
    prog_checksum = 32'h11223344;
    pulse_start();
    expect_now("restart_count_clr", 32'd0, 32'(load_count));
    expect_now("restart_error_clr", 32'd0, {31'd0, load_error});
    for (int i = 0; i < 6; i++) send_byte(8'h11 * 8'(i + 1));
    pulse_end();
    expect_now("partial_count", 32'd1, 32'(load_count));
    expect_now("partial_error", 32'd1, {31'd0, load_error});
    expect_fetch("partial_ram0", 32'h0, 32'h11223344);
    expect_fetch("partial_ram1_kept", 32'h4, 32'h0c000003);

    // Fourth byte together with prog_end
    prog_checksum = 32'haabbccdd;
    pulse_start();
    send_byte(8'haa);
    send_byte(8'hbb);
    send_byte(8'hcc);
    prog_valid = 1'b1;
    prog_byte  = 8'hdd;
    prog_end   = 1'b1;
    tick();
    prog_valid = 1'b0;
    prog_end   = 1'b0;
    expect_now("byte_end_count", 32'd1, 32'(load_count));
    expect_now("byte_end_error", 32'd0, {31'd0, load_error});
    expect_now("byte_end_hold",  32'd0, {31'd0, cpu_hold});
    expect_fetch("byte_end_ram0", 32'h0, 32'haabbccdd);

    // Reset in the middle of a load
    pulse_start();
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_now("rst_mid_hold",  32'd0, {31'd0, cpu_hold});
    expect_now("rst_mid_ready", 32'd0, {31'd0, prog_ready});
    expect_now("rst_mid_count", 32'd0, 32'(load_count));
    expect_fetch("rst_mid_ram0", 32'h0, 32'h01020304);

    // Overflow: 2^ADDR_BITS + 1 words
    pulse_start();
    for (int w = 0; w < (1 << ADDR_BITS); w++) send_word(32'ha5000000 | 32'(w));
    expect_now("full_count", 32'd256, 32'(load_count));
    expect_now("full_error", 32'd0, {31'd0, load_error});
    send_word(32'ha5000100);
    expect_now("ovf_count", 32'd256, 32'(load_count));
    expect_now("ovf_error", 32'd1, {31'd0, load_error});
    pulse_end();
    expect_now("ovf_end_error", 32'd1, {31'd0, load_error});
    expect_fetch("ovf_ram0_kept", 32'h0,   32'ha5000000);
    expect_fetch("ovf_ram63",     32'hfc,  32'ha500003f);
    expect_fetch("ovf_ram255",    32'h3fc, 32'ha50000ff);
    expect_fetch("ovf_oor",       32'h400, 32'h0);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
